// File: rtl/counter15_frame_accum.sv
// Frame popcount accumulator for a row of (1,5) counters: a registered two-level adder tree
// feeds a frame accumulator whose total is offered over a valid/ready result port.
module counter15_frame_accum #(
    parameter int unsigned LANES  = 8,
    parameter int unsigned SUM_W  = 16,
    parameter int unsigned BEAT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [3*LANES-1:0]   s_data,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [SUM_W-1:0]     m_sum,
    output logic                 m_ovf,
    output logic [BEAT_W-1:0]    m_beats
);

    localparam int unsigned NGRP    = LANES / 4;
    localparam int unsigned TOT_W   = 3 + $clog2(LANES);
    localparam int unsigned ACC_X_W = SUM_W + 1;

    typedef enum logic [1:0] {StAccum, StDrain, StHold} state_e;

    state_e state_q, state_d;

    logic               s0_valid_q, s0_last_q;
    logic [3*LANES-1:0] s0_data_q;
    logic               sa_valid_q, sa_last_q;
    logic [4:0]         sa_grp_q [NGRP];
    logic [4:0]         grp_d    [NGRP];
    logic               sb_valid_q, sb_last_q;
    logic [TOT_W-1:0]   sb_total_q, total_d;
    logic [SUM_W-1:0]   acc_q;
    logic               ovf_q;
    logic [BEAT_W-1:0]  beats_q;
    logic [ACC_X_W-1:0] acc_ext;
    logic               accept, hold, out_xfer;

    // Handshake signals are gated by rst so nothing is offered or taken while in reset.
    assign hold     = (state_q == StHold);
    assign s_ready  = (state_q == StAccum) && !rst;
    assign m_valid  = hold && !rst;
    assign accept   = s_valid && s_ready;
    assign out_xfer = m_valid && m_ready;

    always_comb begin
        for (int g = 0; g < NGRP; g++) begin
            grp_d[g] = '0;
            for (int l = 0; l < 4; l++) begin
                grp_d[g] = grp_d[g] + 5'(s0_data_q[12*g + 3*l +: 3]);
            end
        end
    end

    always_comb begin
        total_d = '0;
        for (int g = 0; g < NGRP; g++) begin
            total_d = total_d + TOT_W'(sa_grp_q[g]);
        end
    end

    assign acc_ext = {1'b0, acc_q} + ACC_X_W'(sb_total_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_q <= 1'b0;
            s0_last_q  <= 1'b0;
            s0_data_q  <= '0;
            sa_valid_q <= 1'b0;
            sa_last_q  <= 1'b0;
            for (int g = 0; g < NGRP; g++) sa_grp_q[g] <= '0;
            sb_valid_q <= 1'b0;
            sb_last_q  <= 1'b0;
            sb_total_q <= '0;
        end else begin
            s0_valid_q <= accept;
            s0_last_q  <= accept && s_last;
            if (accept) s0_data_q <= s_data;
            sa_valid_q <= s0_valid_q;
            sa_last_q  <= s0_last_q;
            if (s0_valid_q) begin
                for (int g = 0; g < NGRP; g++) sa_grp_q[g] <= grp_d[g];
            end
            sb_valid_q <= sa_valid_q;
            sb_last_q  <= sa_last_q;
            if (sa_valid_q) sb_total_q <= total_d;
        end
    end

    // The pipeline is empty in HOLD, so a result handshake never coincides with an update.
    always_ff @(posedge clk) begin
        if (rst || out_xfer) begin
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            beats_q <= '0;
        end else if (sb_valid_q) begin
            acc_q <= acc_ext[SUM_W-1:0];
            if (acc_ext[SUM_W]) ovf_q <= 1'b1;
            if (beats_q != '1) beats_q <= beats_q + BEAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= StAccum;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAccum: if (accept && s_last)        state_d = StDrain;
            StDrain: if (sb_valid_q && sb_last_q) state_d = StHold;
            StHold:  if (m_ready)                 state_d = StAccum;
            default:                              state_d = StAccum;
        endcase
    end

    assign m_sum   = m_valid ? acc_q   : '0;
    assign m_ovf   = m_valid ? ovf_q   : 1'b0;
    assign m_beats = m_valid ? beats_q : '0;

endmodule
